// File: rtl/generic_rr_encoder.sv
// Registered round-robin priority encoder with a valid/ack grant handshake.
// Define GRANT_ONEHOT_EN to add a registered one-hot copy of the grant (grant_onehot).
module generic_rr_encoder #(
  parameter int D = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D-1:0]         req,
  input  logic                 enable,
  output logic [$clog2(D)-1:0] grant_idx,
  output logic                 grant_valid,
  input  logic                 grant_ack,
`ifdef GRANT_ONEHOT_EN
  output logic [D-1:0]         grant_onehot,
`endif
  output logic                 busy
);

  localparam int W = $clog2(D);
  localparam logic [W-1:0] PTR_RST = W'(D - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       r_state, w_state_next;
  logic [W-1:0] r_ptr, w_ptr_next;
  logic [W-1:0] r_grant_idx, w_grant_idx_next;
  logic         r_grant_valid, w_grant_valid_next;
  logic [W-1:0] w_win;
  logic         w_found;
  int           w_cand;

  // Scan D positions starting just after the pointer; the wrap is at D, not 2^W.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = 0;
    for (int o = 0; o < D; o++) begin
      w_cand = int'(r_ptr) + 1 + o;
      if (w_cand >= D) w_cand = w_cand - D;
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = W'(w_cand);
      end
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_ptr_next         = r_ptr;
    w_grant_idx_next   = r_grant_idx;
    w_grant_valid_next = r_grant_valid;
    case (r_state)
      IDLE: begin
        if (enable && w_found) begin
          w_state_next       = GRANT;
          w_grant_idx_next   = w_win;
          w_grant_valid_next = 1'b1;
        end
      end
      GRANT: begin
        // The grant is held regardless of req/enable until it is acknowledged.
        if (grant_ack) begin
          w_state_next       = IDLE;
          w_ptr_next         = r_grant_idx;
          w_grant_valid_next = 1'b0;
        end
      end
      default: begin
        w_state_next       = IDLE;
        w_grant_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= PTR_RST;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      r_ptr         <= w_ptr_next;
      r_grant_idx   <= w_grant_idx_next;
      r_grant_valid <= w_grant_valid_next;
    end
  end

`ifdef GRANT_ONEHOT_EN
  logic [D-1:0] r_grant_onehot;
  localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_grant_onehot <= '0;
    else        r_grant_onehot <= w_grant_valid_next ? (ONE << w_grant_idx_next) : '0;
  end

  assign grant_onehot = r_grant_onehot;
`endif

  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;
  assign busy        = (r_state == GRANT);

endmodule

// File: doc/generic_rr_encoder.md
Name: generic_rr_encoder

Overview:
- Registered round-robin priority encoder: turns a D-bit request vector into a binary index, the inverse direction of the register-file one-hot decoder.
- Sits in front of the register file's shared write/read port. Arbitrates among D requesters and presents one binary grant index with a valid/ack handshake.
- The grant index drives the decoder's selector input directly.

Parameters:
- D, 20, number of requesters; index width is W = $clog2(D); D >= 2, need not be a power of two.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  D  request vector; bit k = requester k wants access
- enable  input  1  arbitration enable; gates new grants only
- grant_idx  output  W  registered binary index of granted requester
- grant_valid  output  1  grant_idx is valid and held
- grant_ack  input  1  consumer accepts current grant
- busy  output  1  high while in GRANT state (equals grant_valid)

Behaviour:
- One clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values:
  - grant_idx = 0, grant_valid = 0, busy = 0, state = IDLE.
  - Priority pointer ptr = D-1, so the first search starts at index 0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If enable = 1 and |req = 1, search from (ptr+1) mod D upward, wrapping D-1 -> 0. The first set bit wins.
  - The winner index is registered into grant_idx. grant_valid = 1 on the next edge (1-cycle latency, req to valid). Go to GRANT.
  - Otherwise remain in IDLE with grant_valid = 0. grant_idx holds its last value.
- GRANT:
  - grant_idx and grant_valid are held stable regardless of req or enable changes.
  - If the granted requester drops req, the grant is still held until acked; no withdrawal.
  - On grant_ack = 1: ptr <= grant_idx, grant_valid <= 0, go to IDLE.
  - Throughput: at most one grant per 2 cycles (GRANT -> IDLE -> GRANT).
- grant_ack while in IDLE is ignored; no state change, no pointer update.
- enable low while in GRANT has no effect; it only blocks the next IDLE -> GRANT.
- Index arithmetic:
  - Pointer increment wraps at D, not at 2^W.
  - grant_idx never takes a value >= D.
  - Request bits are indexed 0..D-1 only.
- Fairness: after requester k is acked, k has lowest priority in the next search. No requester with a continuously asserted req waits more than D-1 grants.
- Simultaneous events:
  - req changes in the same cycle as the IDLE search: the sampled req at that edge is used.
  - Ack and a new request on the same edge: the ack is processed; the new request is searched in the following IDLE cycle.
- Reset mid-GRANT: outputs clear immediately (asynchronously). ptr returns to D-1. The pending grant is discarded.

Optional Feature:
- Macro GRANT_ONEHOT_EN.
- Defined:
  - Adds output port grant_onehot [D-1:0], registered.
  - Equals (1 << grant_idx) while grant_valid = 1, else all zeros; reset value 0.
  - Updated on the same edges as grant_idx and grant_valid, so it is cycle-aligned with them.
  - Lets consumers bypass an external decoder.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset then req = 0x00020 (bit 5), enable = 1 -> next cycle grant_idx = 5, grant_valid = 1. With the macro defined, grant_onehot = 0x00020.
- req = 0xFFFFF held, ack asserted one cycle after each valid -> grant sequence 0,1,2,...,19,0. Each grant is valid for exactly one GRANT cycle when acked immediately.
- Wrap: after a grant of 19 is acked, req = bits 3 and 19 -> grant_idx = 3. Then after ack, req = bits 3 and 19 -> grant_idx = 19.
- Hold: grant of 7 issued, grant_ack low for 10 cycles while req toggles and enable drops -> grant_idx stays 7 and grant_valid stays 1 throughout. Ack -> valid = 0 next cycle.
- enable = 0 with req = 0xFFFFF for 5 cycles -> grant_valid stays 0. grant_ack pulses in IDLE cause no pointer change: with enable raised, the first grant is 0.
- rst_n pulsed low mid-GRANT (grant_idx = 12) -> grant_valid = 0 and grant_idx = 0 immediately. After release with req = 0xFFFFF, the first grant is 0.
